mmio_bus_router: RTL and testbench

- Next-generation data-memory address decoder for the RISC-V core.
- Routes each CPU load/store either to data RAM (zero-wait, combinational) or to one of N_PERIPH memory-mapped peripheral windows (UART first).
- Peripheral accesses use a request/ready handshake. The router stalls the CPU until ready or timeout, then returns registered read data with an error pulse on timeout.

---
 rtl/mmio_bus_router.sv | 169 ++++++++++++++++
 tb/tb_mmio_bus_router.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_router.sv
// mmio_bus_router: data-side address decoder for the RISC-V core. Accesses
// outside the peripheral windows go to zero-wait data RAM; accesses inside a
// window run a ready/timeout handshake with the addressed peripheral while the
// CPU is stalled, then present registered read data for one DONE cycle.
module mmio_bus_router #(
  parameter int unsigned N_PERIPH    = 2,
  parameter logic [31:0] PERIPH_BASE = 32'h40,
  parameter int unsigned SPAN_LOG2   = 4,
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memWrite,
  input  logic                   memRead,
  input  logic [31:0]            Addr,
  input  logic [31:0]            WData,
  input  logic [31:0]            mem_rdata,
  output logic [31:0]            Rd_data,
  output logic                   Rd_sel,
  output logic                   stall,
  output logic                   bus_err,
  output logic                   WEM,
  output logic [N_PERIPH-1:0]    periph_sel,
  output logic                   periph_we,
  output logic                   periph_re,
  output logic [SPAN_LOG2-1:0]   periph_addr,
  output logic [31:0]            periph_wdata,
  input  logic [32*N_PERIPH-1:0] periph_rdata,
  input  logic [N_PERIPH-1:0]    periph_ready
);

  localparam int unsigned IDX_W     = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(N_PERIPH) << SPAN_LOG2;
  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          offset;
  logic                 hit;
  logic                 req;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_q;
  logic [SPAN_LOG2-1:0] off_q;
  logic [31:0]          wdata_q;
  logic                 is_write_q;
  logic [7:0]           cnt_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic [N_PERIPH-1:0]  sel_onehot;
  logic                 ready_sel;
  logic                 timeout_hit;
  logic [31:0]          rd_slice;

  // Window decode: unsigned subtract plus range check, so addresses below the
  // base wrap to a huge offset and can never hit.
  always_comb begin
    offset = Addr - PERIPH_BASE;
    hit    = (Addr >= PERIPH_BASE) && (offset < WIN_BYTES);
    idx    = offset[SPAN_LOG2 +: IDX_W];
    req    = hit && (memWrite || memRead);
  end

  // Per-peripheral select, ready and read-data mux for the latched index;
  // ready from any other peripheral never reaches the FSM.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel_onehot = '0;
    rd_slice   = '0;
    for (int i = 0; i < int'(N_PERIPH); i++) begin
      sel_onehot[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) rd_slice = periph_rdata[i*32 +: 32];
    end
    ready_sel   = |(periph_ready & sel_onehot);
    timeout_hit = (cnt_q + 8'd1) == TIMEOUT_C;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    WEM        = 1'b0;
    periph_sel = '0;
    periph_we  = 1'b0;
    periph_re  = 1'b0;
    Rd_sel     = 1'b0;
    bus_err    = 1'b0;
    Rd_data    = mem_rdata;
    case (state_q)
      S_IDLE: begin
        WEM = memWrite && !hit;
        if (req) begin
          stall   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall      = 1'b1;
        periph_sel = sel_onehot;
        periph_we  = is_write_q;
        periph_re  = !is_write_q;
        if (ready_sel || timeout_hit) state_d = S_DONE;
      end
      S_DONE: begin
        Rd_sel  = !is_write_q;
        Rd_data = rdata_q;
        bus_err = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, wait counter and completion capture. Ready takes priority
  // over a timeout that lands in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_q      <= idx;
            off_q      <= offset[SPAN_LOG2-1:0];
            wdata_q    <= WData;
            is_write_q <= memWrite;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (ready_sel) begin
            if (!is_write_q) rdata_q <= rd_slice;
          end else if (timeout_hit) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
          end
        end
        S_DONE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign periph_addr  = off_q;
  assign periph_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bus_router.sv
// Scoreboard bench for mmio_bus_router: stimulus pushes expected peripheral
// requests and completions into queues, a negedge monitor pops and compares
// them when the DUT raises a strobe or releases stall.
module tb_mmio_bus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        memWrite, memRead;
  logic [31:0] Addr, WData, mem_rdata;
  logic [31:0] Rd_data;
  logic        Rd_sel, stall, bus_err, WEM;
  logic [1:0]  periph_sel;
  logic        periph_we, periph_re;
  logic [3:0]  periph_addr;
  logic [31:0] periph_wdata;
  logic [63:0] periph_rdata;
  logic [1:0]  periph_ready;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    int          stall_len;
    logic        rd_sel;
    logic        chk_data;
    logic [31:0] rd_data;
    logic        err;
  } cpl_exp_t;

  req_exp_t req_q[$];
  cpl_exp_t cpl_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  int mon_run = 0;
  logic mon_strobe_prev = 1'b0;

  mmio_bus_router dut (
    .clk          (clk),
    .rst          (rst),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .Addr         (Addr),
    .WData        (WData),
    .mem_rdata    (mem_rdata),
    .Rd_data      (Rd_data),
    .Rd_sel       (Rd_sel),
    .stall        (stall),
    .bus_err      (bus_err),
    .WEM          (WEM),
    .periph_sel   (periph_sel),
    .periph_we    (periph_we),
    .periph_re    (periph_re),
    .periph_addr  (periph_addr),
    .periph_wdata (periph_wdata),
    .periph_rdata (periph_rdata),
    .periph_ready (periph_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares a request on each rising strobe and a completion each
  // time stall drops after a stalled run.
  initial begin : monitor
    req_exp_t r;
    cpl_exp_t c;
    forever begin
      @(negedge clk);
      if (bus_err) err_seen++;
      if (rst) begin
        mon_run = 0;
        mon_strobe_prev = 1'b0;
      end else begin
        if ((periph_we || periph_re) && !mon_strobe_prev) begin
          if (req_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_request: sel=%b addr=%h", periph_sel, periph_addr);
          end else begin
            r = req_q.pop_front();
            check("req_sel",   32'(periph_sel),  32'(r.sel));
            check("req_addr",  32'(periph_addr), 32'(r.addr));
            check("req_we",    32'(periph_we),   32'(r.we));
            check("req_re",    32'(periph_re),   32'(r.re));
            check("req_wdata", periph_wdata,     r.wdata);
            check("req_wem",   32'(WEM),         32'd0);
          end
        end
        mon_strobe_prev = periph_we || periph_re;
        if (stall) begin
          mon_run++;
        end else if (mon_run > 0) begin
          if (cpl_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_completion: stall_len=%0d", mon_run);
          end else begin
            c = cpl_q.pop_front();
            check("cpl_stall_len", 32'(mon_run), 32'(c.stall_len));
            check("cpl_rd_sel",    32'(Rd_sel),  32'(c.rd_sel));
            check("cpl_bus_err",   32'(bus_err), 32'(c.err));
            check("cpl_strobes",   32'({periph_we, periph_re}), 32'd0);
            if (c.chk_data) check("cpl_rd_data", Rd_data, c.rd_data);
          end
          mon_run = 0;
        end
      end
    end
  end

  // One peripheral access: request cycle, then WAIT cycles driving ready on
  // cycle rdy_at (0 = never) for peripheral tgt, with the other peripheral's
  // ready asserted on cycles 1..noise_upto.
  task automatic periph_access(input logic [31:0] a, input logic w, input logic r,
                               input logic [31:0] wd, input int rdy_at, input int tgt,
                               input logic [31:0] rd, input int noise_upto);
    int c;
    Addr = a; memWrite = w; memRead = r; WData = wd;
    periph_ready = '0;
    periph_rdata = (tgt == 0) ? {~rd, rd} : {rd, ~rd};
    #1;
    check("req_cycle_stall", 32'(stall), 32'd1);
    check("req_cycle_wem",   32'(WEM),   32'd0);
    @(posedge clk); #1;
    memWrite = 1'b0; memRead = 1'b0; Addr = 32'h0; WData = 32'h0;
    c = 1;
    while (stall && c < 64) begin
      periph_ready = '0;
      if (c <= noise_upto) periph_ready[1-tgt] = 1'b1;
      if (c == rdy_at)     periph_ready[tgt]   = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    periph_ready = '0;
    check("done_stall_released", 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_req(input logic [1:0] sel, input logic [3:0] addr,
                          input logic we, input logic re, input logic [31:0] wd);
    req_exp_t r;
    r.sel = sel; r.addr = addr; r.we = we; r.re = re; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic push_cpl(input int len, input logic rs, input logic cd,
                          input logic [31:0] data, input logic err);
    cpl_exp_t c;
    c.stall_len = len; c.rd_sel = rs; c.chk_data = cd; c.rd_data = data; c.err = err;
    cpl_q.push_back(c);
    if (err) err_exp++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; memWrite = 1'b0; memRead = 1'b0; Addr = 32'h0; WData = 32'h0;
    mem_rdata = 32'h5555AAAA; periph_rdata = '0; periph_ready = '0;

    // Reset state
    #2;
    check("rst_stall",  32'(stall),      32'd0);
    check("rst_wem",    32'(WEM),        32'd0);
    check("rst_sel",    32'(periph_sel), 32'd0);
    check("rst_strobe", 32'({periph_we, periph_re}), 32'd0);
    check("rst_paddr",  32'(periph_addr), 32'd0);
    check("rst_pwdata", periph_wdata,    32'd0);
    check("rst_rd_sel", 32'(Rd_sel),     32'd0);
    check("rst_bus_err", 32'(bus_err),   32'd0);
    check("rst_rd_data", Rd_data,        32'h5555AAAA);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // RAM store and load, ready in IDLE ignored
    Addr = 32'h10; memWrite = 1'b1; WData = 32'h77; periph_ready = 2'b11; #1;
    check("ram_wem",   32'(WEM),        32'd1);
    check("ram_stall", 32'(stall),      32'd0);
    check("ram_sel",   32'(periph_sel), 32'd0);
    @(posedge clk); #1;
    memWrite = 1'b0; memRead = 1'b1; mem_rdata = 32'h1234; #1;
    check("ram_rd_data", Rd_data,    32'h1234);
    check("ram_rd_sel",  32'(Rd_sel), 32'd0);
    check("ram_rd_wem",  32'(WEM),    32'd0);
    @(posedge clk); #1;
    check("idle_ready_ignored", 32'(stall), 32'd0);
    memRead = 1'b0; periph_ready = '0;
    @(posedge clk); #1;

    // UART read, ready on 3rd WAIT cycle
    push_req(2'b01, 4'h4, 1'b0, 1'b1, 32'h0);
    push_cpl(4, 1'b1, 1'b1, 32'hA5, 1'b0);
    periph_access(32'h44, 1'b0, 1'b1, 32'h0, 3, 0, 32'hA5, 0);

    // Peripheral 1 write, ready[0] noise ignored, ready[1] on cycle 4
    push_req(2'b10, 4'h8, 1'b1, 1'b0, 32'hCAFE);
    push_cpl(5, 1'b0, 1'b0, 32'h0, 1'b0);
    periph_access(32'h58, 1'b1, 1'b0, 32'hCAFE, 4, 1, 32'h0, 3);

    // Timeout read: 1 + 15 stall cycles, error data and pulse
    push_req(2'b01, 4'h0, 1'b0, 1'b1, 32'h0);
    push_cpl(16, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    periph_access(32'h40, 1'b0, 1'b1, 32'h0, 0, 0, 32'h11111111, 0);

    // Ready on the 15th WAIT cycle wins over the timeout
    push_req(2'b01, 4'h0, 1'b0, 1'b1, 32'h0);
    push_cpl(16, 1'b1, 1'b1, 32'h0F0F1234, 1'b0);
    periph_access(32'h40, 1'b0, 1'b1, 32'h0, 15, 0, 32'h0F0F1234, 0);

    // Peripheral 1 read, ready on first WAIT cycle: data two cycles after request
    push_req(2'b10, 4'hC, 1'b0, 1'b1, 32'h0);
    push_cpl(2, 1'b1, 1'b1, 32'h600DF00D, 1'b0);
    periph_access(32'h5C, 1'b0, 1'b1, 32'h0, 1, 1, 32'h600DF00D, 0);

    // Window boundaries stay on the RAM path
    Addr = 32'h3F; memWrite = 1'b1; #1;
    check("bnd_3f_wem",   32'(WEM),   32'd1);
    check("bnd_3f_stall", 32'(stall), 32'd0);
    Addr = 32'h60; #1;
    check("bnd_60_wem",   32'(WEM),   32'd1);
    check("bnd_60_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    memWrite = 1'b0;
    @(posedge clk); #1;

    // Simultaneous store and load is a write
    push_req(2'b10, 4'h0, 1'b1, 1'b0, 32'hBEEF0001);
    push_cpl(2, 1'b0, 1'b0, 32'h0, 1'b0);
    periph_access(32'h50, 1'b1, 1'b1, 32'hBEEF0001, 1, 1, 32'h0, 0);

    // Reset on the 2nd WAIT cycle aborts silently
    push_req(2'b01, 4'h8, 1'b0, 1'b1, 32'h0);
    Addr = 32'h48; memRead = 1'b1;
    @(posedge clk); #1;
    memRead = 1'b0; Addr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("mid_rst_stall",  32'(stall),      32'd0);
    check("mid_rst_sel",    32'(periph_sel), 32'd0);
    check("mid_rst_strobe", 32'({periph_we, periph_re}), 32'd0);
    check("mid_rst_paddr",  32'(periph_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Normal request after reset
    push_req(2'b01, 4'h4, 1'b0, 1'b1, 32'h0);
    push_cpl(2, 1'b1, 1'b1, 32'h00C0FFEE, 1'b0);
    periph_access(32'h44, 1'b0, 1'b1, 32'h0, 1, 0, 32'h00C0FFEE, 0);

    repeat (3) @(posedge clk);
    #1;
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("cpl_q_drained", 32'(cpl_q.size()), 32'd0);
    check("bus_err_pulses", 32'(err_seen), 32'(err_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
